// File: rtl/address_bus.sv
// CPU address decoder for the mapache64 console: registered one-hot device select plus region-relative offset.
// Optional sticky unmapped-access flag enabled by defining ADDRESS_BUS_ILLEGAL_FLAG_EN.

package address_bus_pkg;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_VRAM,
    RGN_FIRMWARE,
    RGN_ROM,
    RGN_IN_VBLANK,
    RGN_CLR_VBLANK_IRQ,
    RGN_CONTROLLER
  } region_e;

  // Bases are kept 15 bits wide: the offset is truncated to 15 bits anyway,
  // so subtracting only the low bits gives the same result.
  localparam logic [14:0] RAM_BASE      = 15'h0000;
  localparam logic [14:0] VRAM_BASE     = 15'h3700;
  localparam logic [14:0] FIRMWARE_BASE = 15'h4000;
  localparam logic [14:0] IO_BASE       = 15'h7000;
  localparam logic [14:0] ROM_BASE      = 15'h0000;  // 0x8000 with bit 15 dropped

  localparam logic [15:0] VRAM_START     = 16'h3700;
  localparam logic [15:0] FIRMWARE_START = 16'h4000;

  function automatic region_e decode_region(input logic [15:0] addr);
    region_e rgn;
    if (addr[15]) begin
      rgn = RGN_ROM;
    end else if (addr[14:12] == 3'b111) begin
      // 0x7000-0x7FFF: only the first four words are populated I/O registers
      if (addr[11:2] != 10'd0) begin
        rgn = RGN_NONE;
      end else begin
        unique case (addr[1:0])
          2'b00:   rgn = RGN_IN_VBLANK;
          2'b01:   rgn = RGN_CLR_VBLANK_IRQ;
          default: rgn = RGN_CONTROLLER;
        endcase
      end
    end else if (addr >= FIRMWARE_START) begin
      rgn = RGN_FIRMWARE;
    end else if (addr >= VRAM_START) begin
      rgn = RGN_VRAM;
    end else begin
      rgn = RGN_RAM;
    end
    return rgn;
  endfunction

  function automatic logic [14:0] region_base(input region_e rgn);
    logic [14:0] base;
    unique case (rgn)
      RGN_RAM:      base = RAM_BASE;
      RGN_VRAM:     base = VRAM_BASE;
      RGN_FIRMWARE: base = FIRMWARE_BASE;
      RGN_ROM:      base = ROM_BASE;
      default:      base = IO_BASE;  // I/O registers and the unmapped hole
    endcase
    return base;
  endfunction

endpackage

module address_bus
  import address_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_address,
  output logic [14:0] output_address,
  output logic        SELECT_ram,
  output logic        SELECT_vram,
  output logic        SELECT_firmware,
  output logic        SELECT_rom,
  output logic        SELECT_in_vblank,
  output logic        SELECT_clr_vblank_irq,
  output logic        SELECT_controller
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
  ,
  output logic        illegal_access
`endif
);

  region_e     region_next;
  logic [14:0] offset_next;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    region_next = RGN_NONE;
    offset_next = 15'd0;
    region_next = decode_region(cpu_address);
    offset_next = cpu_address[14:0] - region_base(region_next);
  end

  // NOTE: async active-low reset with non-blocking assignments; outputs clear the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_address        <= 15'd0;
      SELECT_ram            <= 1'b0;
      SELECT_vram           <= 1'b0;
      SELECT_firmware       <= 1'b0;
      SELECT_rom            <= 1'b0;
      SELECT_in_vblank      <= 1'b0;
      SELECT_clr_vblank_irq <= 1'b0;
      SELECT_controller     <= 1'b0;
    end else begin
      output_address        <= offset_next;
      SELECT_ram            <= (region_next == RGN_RAM);
      SELECT_vram           <= (region_next == RGN_VRAM);
      SELECT_firmware       <= (region_next == RGN_FIRMWARE);
      SELECT_rom            <= (region_next == RGN_ROM);
      SELECT_in_vblank      <= (region_next == RGN_IN_VBLANK);
      SELECT_clr_vblank_irq <= (region_next == RGN_CLR_VBLANK_IRQ);
      SELECT_controller     <= (region_next == RGN_CONTROLLER);
    end
  end

`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
  // Sticky: once an unmapped address is sampled only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_access <= 1'b0;
    end else if (region_next == RGN_NONE) begin
      illegal_access <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_address_bus.sv
// Self-checking bench for address_bus: directed vector table, reset/flag sequences and a random latency sweep.
// Exercises the illegal_access flag when ADDRESS_BUS_ILLEGAL_FLAG_EN is defined.

module tb_address_bus;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_RAM  = 7'b1000000;
  localparam logic [6:0] S_VRAM = 7'b0100000;
  localparam logic [6:0] S_FW   = 7'b0010000;
  localparam logic [6:0] S_ROM  = 7'b0001000;
  localparam logic [6:0] S_VBL  = 7'b0000100;
  localparam logic [6:0] S_CLR  = 7'b0000010;
  localparam logic [6:0] S_CTL  = 7'b0000001;

  typedef struct packed {
    logic [15:0] addr;
    logic [6:0]  sel;
    logic [14:0] off;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_address;
  logic [14:0] output_address;
  logic        SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom;
  logic        SELECT_in_vblank, SELECT_clr_vblank_irq, SELECT_controller;
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
  logic        illegal_access;
`endif

  int n_checks = 0;
  int n_errors = 0;

  address_bus dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cpu_address          (cpu_address),
    .output_address       (output_address),
    .SELECT_ram           (SELECT_ram),
    .SELECT_vram          (SELECT_vram),
    .SELECT_firmware      (SELECT_firmware),
    .SELECT_rom           (SELECT_rom),
    .SELECT_in_vblank     (SELECT_in_vblank),
    .SELECT_clr_vblank_irq(SELECT_clr_vblank_irq),
    .SELECT_controller    (SELECT_controller)
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
    ,
    .illegal_access       (illegal_access)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] sel_vec();
    return {SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
            SELECT_in_vblank, SELECT_clr_vblank_irq, SELECT_controller};
  endfunction

  // Plain range-based reference of the memory map.
  function automatic void ref_decode(input logic [15:0] a, output logic [6:0] sel,
                                     output logic [14:0] off);
    logic [15:0] base;
    logic [15:0] diff;
    if (a <= 16'h36FF)      begin sel = S_RAM;  base = 16'h0000; end
    else if (a <= 16'h3FFF) begin sel = S_VRAM; base = 16'h3700; end
    else if (a <= 16'h6FFF) begin sel = S_FW;   base = 16'h4000; end
    else if (a >= 16'h8000) begin sel = S_ROM;  base = 16'h8000; end
    else begin
      base = 16'h7000;
      if (a == 16'h7000)                        sel = S_VBL;
      else if (a == 16'h7001)                   sel = S_CLR;
      else if (a == 16'h7002 || a == 16'h7003)  sel = S_CTL;
      else                                      sel = S_NONE;
    end
    diff = a - base;
    off  = diff[14:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] a);
    cpu_address = a;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    logic [6:0]  exp_sel;
    logic [14:0] exp_off;
    logic [15:0] a;
    logic        sticky;

    vecs = '{
      '{16'h0000, S_RAM,  15'h0000},
      '{16'h36FF, S_RAM,  15'h36FF},
      '{16'h3700, S_VRAM, 15'h0000},
      '{16'h3FFF, S_VRAM, 15'h08FF},
      '{16'h4000, S_FW,   15'h0000},
      '{16'h6FFF, S_FW,   15'h2FFF},
      '{16'h8000, S_ROM,  15'h0000},
      '{16'hFFFF, S_ROM,  15'h7FFF},
      '{16'h7000, S_VBL,  15'h0000},
      '{16'h7001, S_CLR,  15'h0001},
      '{16'h7002, S_CTL,  15'h0002},
      '{16'h7003, S_CTL,  15'h0003},
      '{16'h7004, S_NONE, 15'h0004},
      '{16'h7FFF, S_NONE, 15'h0FFF}
    };

    // Reset held with a ROM address on the bus
    rst_n = 1'b0;
    cpu_address = 16'h8000;
    #22;
    check("reset_sel", 32'(sel_vec()), 32'(S_NONE));
    check("reset_off", 32'(output_address), 32'h0);
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
    check("reset_illegal", 32'(illegal_access), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_sel", 32'(sel_vec()), 32'(S_ROM));
    check("first_edge_off", 32'(output_address), 32'h0);

    // Directed table; the unmapped entries come last so the sticky flag is tested after
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].addr);
      check($sformatf("vec%0d_sel_%04h", i, vecs[i].addr), 32'(sel_vec()), 32'(vecs[i].sel));
      check($sformatf("vec%0d_off_%04h", i, vecs[i].addr), 32'(output_address), 32'(vecs[i].off));
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
      check($sformatf("vec%0d_illegal", i), 32'(illegal_access), (i >= 12) ? 32'h1 : 32'h0);
`endif
    end

    // Flag stays set after returning to a mapped address until reset pulses
    step(16'h0000);
    check("after_unmapped_sel", 32'(sel_vec()), 32'(S_RAM));
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
    check("illegal_sticky", 32'(illegal_access), 32'h1);
`endif
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(16'h0000);
    check("post_pulse_sel", 32'(sel_vec()), 32'(S_RAM));
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
    check("illegal_cleared", 32'(illegal_access), 32'h0);
`endif

    // Async reset mid-cycle while VRAM is selected
    step(16'h3A00);
    check("pre_async_sel", 32'(sel_vec()), 32'(S_VRAM));
    check("pre_async_off", 32'(output_address), 32'h0300);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(sel_vec()), 32'(S_NONE));
    check("async_off", 32'(output_address), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random sweep: one-cycle latency and at most one select high
    sticky = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      if (i % 50 == 0) a = 16'h7004 + 16'($urandom_range(0, 16'h0FFB));
      step(a);
      ref_decode(a, exp_sel, exp_off);
      sticky = sticky | (exp_sel == S_NONE);
      check($sformatf("rand%0d_sel_%04h", i, a), 32'(sel_vec()), 32'(exp_sel));
      check($sformatf("rand%0d_off_%04h", i, a), 32'(output_address), 32'(exp_off));
      check($sformatf("rand%0d_onehot", i), 32'($countones(sel_vec()) <= 1), 32'h1);
`ifdef ADDRESS_BUS_ILLEGAL_FLAG_EN
      check($sformatf("rand%0d_illegal", i), 32'(illegal_access), 32'(sticky));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/address_bus.md
# address_bus

CPU address decoder for the mapache64 console. It takes the 16-bit 6502-style CPU address and asserts exactly one device select for RAM, VRAM, firmware, ROM or one of the memory-mapped I/O registers. It also produces a 15-bit region-relative offset for the selected device. It sits between the CPU core and the memory/peripheral blocks, and its outputs are registered to the system clock.

## Interface
- No parameters; the memory map is fixed.
- clk  input  1  system clock; all registers update on the rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- cpu_address  input  16  CPU address bus
- output_address  output  15  offset of cpu_address within the selected region
- SELECT_ram  output  1  region 0x0000–0x36FF
- SELECT_vram  output  1  region 0x3700–0x3FFF
- SELECT_firmware  output  1  region 0x4000–0x6FFF
- SELECT_rom  output  1  region 0x8000–0xFFFF
- SELECT_in_vblank  output  1  register 0x7000
- SELECT_clr_vblank_irq  output  1  register 0x7001
- SELECT_controller  output  1  registers 0x7002–0x7003
- illegal_access  output  1  present only with ADDRESS_BUS_ILLEGAL_FLAG_EN

## Operation
- Decode is combinational from cpu_address into next-state values; outputs are the registered values.
- The decoded regions are mutually exclusive: at most one SELECT_* is high.
- output_address = cpu_address − region base, truncated to 15 bits. The region bases are:
  - RAM 0x0000
  - VRAM 0x3700
  - firmware 0x4000
  - ROM 0x8000
  - I/O 0x7000
- output_address examples:
  - 0x36FF → 0x36FF
  - 0x3700 → 0x0000
  - 0x3FFF → 0x08FF
  - 0x6FFF → 0x2FFF
  - 0xFFFF → 0x7FFF
  - 0x7003 → 0x0003
- For controllers, output_address[0] selects controller 1 (0) or controller 2 (1).
- Unmapped range 0x7004–0x7FFF:
  - all SELECT_* are low;
  - output_address = cpu_address − 0x7000, a don't-care for consumers.
- Boundaries are inclusive exactly as listed. Each edge address (0x36FF/0x3700, 0x3FFF/0x4000, 0x6FFF/0x7000, 0x7003/0x7004, 0x7FFF/0x8000) must select the region on its own side of the boundary.

## Timing
- One-cycle latency: outputs at edge N+1 reflect cpu_address sampled at edge N.
- A new address may be presented every cycle; the block does not stall and uses no handshake.
- While rst_n is low:
  - all outputs are immediately 0, including illegal_access;
  - output_address = 0x0000.
- Out of reset, the first rising edge with rst_n high loads the decode of the current cpu_address.
- Reset asserted mid-stream clears outputs asynchronously, without waiting for a clock edge.
- All register updates happen on the rising clk edge only.

## Configuration
- Macro: ADDRESS_BUS_ILLEGAL_FLAG_EN.
- Defined:
  - port illegal_access exists and is a sticky flag;
  - it sets on the edge after any address in 0x7004–0x7FFF is sampled;
  - it stays high until rst_n is asserted;
  - select and offset behaviour is unchanged.
- Undefined:
  - the illegal_access port and its register are absent;
  - unmapped accesses are silently ignored.

## Test plan
- Reset: hold rst_n=0 with cpu_address=0x8000 → all SELECT_* =0 and output_address=0x0000. Release reset and clock once → SELECT_rom=1, output_address=0x0000.
- Region edges: apply 0x0000, 0x36FF, 0x3700, 0x3FFF, 0x4000, 0x6FFF, 0x8000, 0xFFFF, one per cycle. One cycle later the outputs are, in order:
  - ram/0x0000
  - ram/0x36FF
  - vram/0x0000
  - vram/0x08FF
  - firmware/0x0000
  - firmware/0x2FFF
  - rom/0x0000
  - rom/0x7FFF
- I/O: apply 0x7000, 0x7001, 0x7002, 0x7003 → in_vblank, then clr_vblank_irq, then controller with output_address 0x0002, then controller with 0x0003.
- Unmapped: apply 0x7004 and 0x7FFF → no select asserted. With ADDRESS_BUS_ILLEGAL_FLAG_EN, illegal_access=1 and stays 1 after applying 0x0000, until rst_n pulses low.
- Latency/one-hot: drive a random address each cycle for 10k cycles → outputs always equal the reference decode of the previous cycle's address, and at most one SELECT_* is high.
- Async reset mid-stream: pulse rst_n low between clock edges while SELECT_vram=1 → outputs clear without a clock edge.
